// File: rtl/gpi_debounce.sv
// ============================================================================
// Module   : gpi_debounce
// Brief    : Per-bit synchroniser + counter debounce + registered edge pulses
//            for raw board switches/buttons feeding the demo system gp_i.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gpi_debounce #(
    parameter int Width          = 8,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 500000
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] gp_raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    localparam int CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] c_CNT_MAX = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0][Width-1:0] r_sync;
    logic [Width-1:0]                 w_sync;
    logic [Width-1:0]                 w_gp;
    logic [Width-1:0]                 w_rise;
    logic [Width-1:0]                 w_fall;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gp_raw_i;
            for (int s = 1; s < SyncStages; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SyncStages-1];

    generate
        for (genvar i = 0; i < Width; i++) begin : g_bit
            logic [CntW-1:0] r_cnt;
            logic            r_gp;
            logic            r_rise;
            logic            r_fall;
            logic            w_diff;
            logic            w_sat;

            // The compare always uses the current synced value, so a bounce
            // back to the old level on the saturating cycle is rejected.
            always_comb begin
                w_diff = w_sync[i] ^ r_gp;
                w_sat  = (r_cnt == c_CNT_MAX);
            end

            always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
                if (!rst_sys_ni) begin
                    r_cnt  <= '0;
                    r_gp   <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (!w_diff) begin
                        r_cnt <= '0;
                    end else if (w_sat) begin
                        r_cnt  <= '0;
                        r_gp   <= w_sync[i];
                        r_rise <= w_sync[i];
                        r_fall <= ~w_sync[i];
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
            end

            assign w_gp[i]   = r_gp;
            assign w_rise[i] = r_rise;
            assign w_fall[i] = r_fall;
        end
    endgenerate

    assign gp_o   = w_gp;
    assign rise_o = w_rise;
    assign fall_o = w_fall;

endmodule

`default_nettype wire
